me_result_sched: RTL and testbench



---
 rtl/me_pkg.sv | 24 ++
 rtl/me_result_sched_if.sv | 28 ++
 rtl/me_result_fifo.sv | 55 +++++
 rtl/me_result_sched.sv | 130 +++++++++++++
 tb/tb_me_result_sched.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/me_pkg.sv
// Shared widths, result type and scan-state encoding for the ME result scheduler.
package me_pkg;
  localparam int SAD_W = 14;
  localparam int POS_W = 4;
  localparam logic [POS_W-1:0] MV_CENTER = POS_W'(7);

  typedef struct packed {
    logic [SAD_W-1:0] sad;
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
  } me_result_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } scan_state_e;

  // Strictly lower SAD wins; an equal SAD wins only at zero motion.
  function automatic logic cand_better(input me_result_t cand, input me_result_t best);
    return (cand.sad < best.sad) ||
           ((cand.sad == best.sad) && (cand.x == MV_CENTER) && (cand.y == MV_CENTER));
  endfunction
endpackage

// File: rtl/me_result_sched_if.sv
// Candidate stream from the SAD array and issue/status signals toward the serialiser.
interface me_result_sched_if;
  // cand_valid qualifies cand_sad/x/y/last for one cycle; there is no backpressure.
  // ser_en is a one-cycle strobe; ser_sad/x/y are valid with it and held until the next one.
  logic                       blk_start;
  logic                       cand_valid;
  logic [me_pkg::SAD_W-1:0]   cand_sad;
  logic [me_pkg::POS_W-1:0]   cand_x;
  logic [me_pkg::POS_W-1:0]   cand_y;
  logic                       cand_last;
  logic                       ser_en;
  logic [me_pkg::SAD_W-1:0]   ser_sad;
  logic [me_pkg::POS_W-1:0]   ser_x;
  logic [me_pkg::POS_W-1:0]   ser_y;
  logic                       sched_idle;
  logic                       abort_pulse;
  logic                       cnt_err;
  logic                       ovf_err;

  modport master (
    output blk_start, cand_valid, cand_sad, cand_x, cand_y, cand_last,
    input  ser_en, ser_sad, ser_x, ser_y, sched_idle, abort_pulse, cnt_err, ovf_err
  );
  modport slave (
    input  blk_start, cand_valid, cand_sad, cand_x, cand_y, cand_last,
    output ser_en, ser_sad, ser_x, ser_y, sched_idle, abort_pulse, cnt_err, ovf_err
  );
endinterface

// File: rtl/me_result_fifo.sv
// Small synchronous FIFO of ME results; push at full is accepted when a pop happens alongside.
module me_result_fifo
  import me_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  me_result_t push_data_i,
  input  logic       pop_i,
  output me_result_t pop_data_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  me_result_t        mem_q [DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o     = (cnt_q == CW'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign pop_data_o = mem_q[rptr_q];
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d = do_push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = do_pop  ? ptr_inc(rptr_q) : rptr_q;
    cnt_d  = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data_i;
  end
endmodule

// File: rtl/me_result_sched.sv
// Tracks the best SAD candidate per block, queues one result per block and issues
// it to the serialiser with enables spaced SER_GAP cycles apart.
module me_result_sched
  import me_pkg::*;
#(
  parameter int CAND_NUM   = 225,
  parameter int SER_GAP    = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  me_result_sched_if.slave   bus,
  output scan_state_e        dbg_state_o
);
  localparam int GAP_W = $clog2(SER_GAP);

  scan_state_e       state_q, state_d;
  me_result_t        best_q, best_d, ser_q, ser_d, cand, fifo_rd;
  logic              best_vld_q, best_vld_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              ser_en_q, ser_en_d, abort_q, abort_d;
  logic              cnt_err_q, cnt_err_d, ovf_q, ovf_d;
  logic              push, pop, fifo_full, fifo_empty;

  assign cand = '{sad: bus.cand_sad, x: bus.cand_x, y: bus.cand_y};

  always_comb begin
    state_d    = state_q;
    best_d     = best_q;
    best_vld_d = best_vld_q;
    cnt_d      = cnt_q;
    abort_d    = 1'b0;
    cnt_err_d  = 1'b0;
    push       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.blk_start) begin
          state_d    = ST_SCAN;
          best_vld_d = 1'b0;
          cnt_d      = '0;
        end
      end
      ST_SCAN: begin
        // A restart clears first, so a same-cycle candidate opens the new scan.
        if (bus.blk_start) begin
          abort_d    = 1'b1;
          best_vld_d = 1'b0;
          cnt_d      = '0;
        end
        if (bus.cand_valid) begin
          cnt_d = (cnt_d == 8'hFF) ? cnt_d : cnt_d + 8'd1;
          if (!best_vld_d || cand_better(cand, best_q)) begin
            best_d     = cand;
            best_vld_d = 1'b1;
          end
          if (bus.cand_last) state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        push      = 1'b1;
        cnt_err_d = (cnt_q != 8'(CAND_NUM));
        state_d   = bus.blk_start ? ST_SCAN : ST_IDLE;
        if (bus.blk_start) begin
          best_vld_d = 1'b0;
          cnt_d      = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Issue: pop whenever a result waits and the serialiser's shift window has elapsed.
  always_comb begin
    pop      = !fifo_empty && (gap_q == '0);
    ser_en_d = pop;
    ser_d    = pop ? fifo_rd : ser_q;
    ovf_d    = push && fifo_full && !pop;
    if (pop)               gap_d = GAP_W'(SER_GAP - 1);
    else if (gap_q != '0)  gap_d = gap_q - GAP_W'(1);
    else                   gap_d = gap_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      best_q     <= '0;
      best_vld_q <= 1'b0;
      cnt_q      <= '0;
      gap_q      <= '0;
      ser_q      <= '0;
      ser_en_q   <= 1'b0;
      abort_q    <= 1'b0;
      cnt_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      best_q     <= best_d;
      best_vld_q <= best_vld_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      ser_q      <= ser_d;
      ser_en_q   <= ser_en_d;
      abort_q    <= abort_d;
      cnt_err_q  <= cnt_err_d;
      ovf_q      <= ovf_d;
    end
  end

  me_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (best_q),
    .pop_i       (pop),
    .pop_data_o  (fifo_rd),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign bus.ser_en      = ser_en_q;
  assign bus.ser_sad     = ser_q.sad;
  assign bus.ser_x       = ser_q.x;
  assign bus.ser_y       = ser_q.y;
  assign bus.sched_idle  = (state_q == ST_IDLE);
  assign bus.abort_pulse = abort_q;
  assign bus.cnt_err     = cnt_err_q;
  assign bus.ovf_err     = ovf_q;
  assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_me_result_sched.sv
// Bench for me_result_sched: directed scenarios with literal expectations plus a
// random phase, all outputs compared every cycle against a queue-based model.
module tb_me_result_sched;
  import me_pkg::*;

  localparam int CAND_NUM   = 225;
  localparam int SER_GAP    = 16;
  localparam int FIFO_DEPTH = 2;
  localparam int W          = 22;

  logic clk, rst;
  scan_state_e dbg_state;
  me_result_sched_if bus();

  me_result_sched #(.CAND_NUM(CAND_NUM), .SER_GAP(SER_GAP), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters and logs ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_cyc;
  int ser_cnt, abort_cnt, cnt_err_cnt, ovf_cnt;
  logic [W-1:0] ser_log[$];
  int ser_cyc[$];
  logic [W-1:0] blk[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  logic [W-1:0] exp_q[$];
  bit           m_ready = 0;
  bit           m_scan, m_commit, m_have;
  int           m_cnt, m_next_issue;
  logic [W-1:0] m_best;
  bit           e_en, e_abort, e_cnt_err, e_ovf, e_idle;
  logic [W-1:0] e_ser;

  task automatic model_step();
    logic [13:0] cs;
    logic [3:0]  cx, cy;
    cyc++;
    if (rst) begin
      exp_q.delete();
      m_scan = 0; m_commit = 0; m_have = 0; m_cnt = 0; m_best = '0;
      m_next_issue = cyc;
      e_en = 0; e_abort = 0; e_cnt_err = 0; e_ovf = 0; e_idle = 1; e_ser = '0;
      m_ready = 1;
      return;
    end
    e_en = 0; e_abort = 0; e_cnt_err = 0; e_ovf = 0;
    if (exp_q.size() > 0 && cyc >= m_next_issue) begin
      e_ser = exp_q.pop_front();
      e_en = 1;
      m_next_issue = cyc + SER_GAP;
    end
    cs = bus.cand_sad; cx = bus.cand_x; cy = bus.cand_y;
    if (m_commit) begin
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(m_best);
      else e_ovf = 1;
      e_cnt_err = (m_cnt != CAND_NUM);
      m_commit = 0;
      if (bus.blk_start) begin m_scan = 1; m_have = 0; m_cnt = 0; end
    end else if (m_scan) begin
      if (bus.blk_start) begin e_abort = 1; m_have = 0; m_cnt = 0; end
      if (bus.cand_valid) begin
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        if (!m_have || cs < m_best[21:8] || (cs == m_best[21:8] && cx == 4'd7 && cy == 4'd7))
          m_best = {cs, cx, cy};
        m_have = 1;
        if (bus.cand_last) begin m_scan = 0; m_commit = 1; end
      end
    end else if (bus.blk_start) begin
      m_scan = 1; m_have = 0; m_cnt = 0;
    end
    e_idle = !m_scan && !m_commit;
  endtask

  always @(posedge clk) model_step();

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (m_ready) begin
      check("ser_en",      bus.ser_en,      e_en);
      check("ser_sad",     bus.ser_sad,     e_ser[21:8]);
      check("ser_x",       bus.ser_x,       e_ser[7:4]);
      check("ser_y",       bus.ser_y,       e_ser[3:0]);
      check("sched_idle",  bus.sched_idle,  e_idle);
      check("abort_pulse", bus.abort_pulse, e_abort);
      check("cnt_err",     bus.cnt_err,     e_cnt_err);
      check("ovf_err",     bus.ovf_err,     e_ovf);
    end
  end

  // Observation log used by the literal checks.
  always @(negedge clk) begin
    if (bus.ser_en) begin
      ser_cnt++;
      ser_log.push_back({bus.ser_sad, bus.ser_x, bus.ser_y});
      ser_cyc.push_back(cyc);
    end
    if (bus.abort_pulse) abort_cnt++;
    if (bus.cnt_err)     cnt_err_cnt++;
    if (bus.ovf_err)     ovf_cnt++;
  end

  // ---------------- driver tasks ----------------
  function automatic logic [W-1:0] pk(input int s, input int x, input int y);
    return {14'(s), 4'(x), 4'(y)};
  endfunction

  task automatic clear_logs();
    ser_cnt = 0; abort_cnt = 0; cnt_err_cnt = 0; ovf_cnt = 0;
    ser_log.delete(); ser_cyc.delete();
  endtask

  task automatic step(input bit bs, input bit cv, input logic [W-1:0] c, input bit cl);
    bus.blk_start  = bs;
    bus.cand_valid = cv;
    bus.cand_sad   = c[21:8];
    bus.cand_x     = c[7:4];
    bus.cand_y     = c[3:0];
    bus.cand_last  = cl;
    @(posedge clk);
    #1;
    bus.blk_start  = 1'b0;
    bus.cand_valid = 1'b0;
    bus.cand_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic run_block();
    step(1'b1, 1'b0, '0, 1'b0);
    foreach (blk[i]) step(1'b0, 1'b1, blk[i], i == blk.size() - 1);
    last_cyc = cyc;
  endtask

  // Raster-ordered block of n candidates; index min_idx gets min_sad, others exceed it.
  task automatic raster_block(input int n, input int min_idx, input int min_sad);
    blk.delete();
    for (int i = 0; i < n; i++)
      blk.push_back(pk((i == min_idx) ? min_sad : int'($urandom_range(min_sad + 1, 16383)),
                       i % 15, (i / 15) % 15));
  endtask

  task automatic random_phase(input int n);
    bit bs, cv, cl;
    int s, x, y;
    for (int i = 0; i < n; i++) begin
      bs = ($urandom_range(0, 19) == 0);
      cv = ($urandom_range(0, 3) != 0);
      cl = ($urandom_range(0, 7) == 0);
      s  = $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) begin x = 7; y = 7; end
      else begin x = $urandom_range(0, 14); y = $urandom_range(0, 14); end
      rst = ($urandom_range(0, 999) == 0);
      step(bs, cv, pk(s, x, y), cl);
      rst = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] r;

  initial begin
    rst = 1'b1;
    bus.blk_start = 0; bus.cand_valid = 0; bus.cand_last = 0;
    bus.cand_sad = '0; bus.cand_x = '0; bus.cand_y = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_idle", bus.sched_idle, 1);
    check("reset_ser_en", bus.ser_en, 0);
    idle(2);

    // Unique minimum 100 at (3,12) in a full block.
    clear_logs();
    raster_block(225, 12 * 15 + 3, 100);
    run_block();
    idle(30);
    check("t1_ser_count", ser_cnt, 1);
    check("t1_cnt_err", cnt_err_cnt, 0);
    if (ser_log.size() > 0) begin
      r = ser_log[0];
      check("t1_sad", r[21:8], 100);
      check("t1_x", r[7:4], 3);
      check("t1_y", r[3:0], 12);
      check("t1_latency", ser_cyc[0] - last_cyc, 2);
    end

    // Tie-breaks.
    clear_logs();
    blk = '{pk(50, 0, 0), pk(50, 7, 7)};
    run_block(); idle(20);
    blk = '{pk(50, 7, 7), pk(50, 2, 2)};
    run_block(); idle(20);
    blk = '{pk(16383, 5, 9), pk(16383, 1, 1), pk(16383, 14, 0), pk(16383, 0, 14), pk(16383, 3, 3)};
    run_block(); idle(20);
    check("t2_ser_count", ser_cnt, 3);
    if (ser_log.size() == 3) begin
      check("t2a_pos", ser_log[0], pk(50, 7, 7));
      check("t2b_pos", ser_log[1], pk(50, 7, 7));
      check("t2c_pos", ser_log[2], pk(16383, 5, 9));
    end

    // Four 4-candidate blocks back to back.
    clear_logs();
    for (int b = 0; b < 4; b++) begin
      raster_block(4, $urandom_range(0, 3), $urandom_range(0, 1000));
      run_block();
      if (b == 0) r = W'(last_cyc);
    end
    idle(60);
    check("t3_ser_count", ser_cnt, 3);
    check("t3_ovf", ovf_cnt, 1);
    check("t3_cnt_err", cnt_err_cnt, 4);
    if (ser_cyc.size() >= 2) begin
      check("t3_first_latency", ser_cyc[0] - int'(r), 2);
      check("t3_gap", ser_cyc[1] - ser_cyc[0], SER_GAP);
    end

    // Abort after 10 candidates, then a full block whose minimum is 77 at (9,4).
    clear_logs();
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, pk(5 + i, i, 0), 1'b0);
    raster_block(225, 4 * 15 + 9, 77);
    run_block();
    idle(40);
    check("t4_abort", abort_cnt, 1);
    check("t4_ser_count", ser_cnt, 1);
    if (ser_log.size() > 0) check("t4_result", ser_log[0], pk(77, 9, 4));

    // Reset with two queued results and the gap counter at 9.
    clear_logs();
    blk = '{pk(20, 1, 2)}; run_block();
    blk = '{pk(30, 3, 4)}; run_block();
    blk = '{pk(40, 5, 6)}; run_block();
    idle(4);
    check("t5_pre_ser_count", ser_cnt, 1);
    rst = 1'b1;
    step(1'b0, 1'b0, '0, 1'b0);
    rst = 1'b0;
    check("t5_idle", bus.sched_idle, 1);
    check("t5_ser_en", bus.ser_en, 0);
    check("t5_ser_data", {bus.ser_sad, bus.ser_x, bus.ser_y}, 0);
    clear_logs();
    idle(40);
    check("t5_no_ser", ser_cnt, 0);

    // Count saturation: 481 candidates must not wrap back to 225.
    clear_logs();
    raster_block(481, 300, 10);
    run_block();
    idle(20);
    check("sat_cnt_err", cnt_err_cnt, 1);

    random_phase(3000);
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
